// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared arithmetic package for the sequential multiplier (and the divider beside it).
// Contents:
//   SIZE_DEFAULT - default operand width, common to the multiplier and the divider.
//   state_e      - control FSM state encoding.
package seq_shift_add_multiplier_pkg;

  localparam int unsigned SIZE_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_add_multiplier_addsub.sv
// Ripple-carry adder/subtractor cell, shared with the restoring divider.
// Ports:
//   a    [size-1:0] in  - first operand
//   b    [size-1:0] in  - second operand
//   mode            in  - 0: a + b, 1: a - b (two's complement, carry-in 1)
//   sum  [size-1:0] out - result
//   cout            out - carry out of the top bit (inverted borrow in subtract mode)
module seq_shift_add_multiplier_addsub
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int unsigned size = SIZE_DEFAULT
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            mode,
  output logic [size-1:0] sum,
  output logic            cout
);

  logic [size:0]   carry;
  logic [size-1:0] b_eff;

  always_comb begin
    b_eff    = b ^ {size{mode}};
    carry    = '0;
    carry[0] = mode;
    sum      = '0;
    for (int i = 0; i < int'(size); i++) begin
      sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (a[i] & carry[i]) | (b_eff[i] & carry[i]);
    end
    cout = carry[size];
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk                    in  - clock, rising edge
//   rst_n                  in  - synchronous active-low reset
//   start                  in  - operation request, only honoured while idle
//   A        [SIZE-1:0]    in  - multiplicand, captured on accepted start
//   B        [SIZE-1:0]    in  - multiplier, captured on accepted start
//   product  [2*SIZE-1:0]  out - registered A*B, held until the next completion
//   busy                   out - operation in progress (CALC or DONE)
//   done                   out - one-cycle pulse, product valid from this cycle on
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   A,
  input  logic [SIZE-1:0]   B,
  output logic [2*SIZE-1:0] product,
  output logic              busy,
  output logic              done
);

  localparam int unsigned  CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  state_e              state_q, state_d;
  logic [SIZE-1:0]     m_q, m_d;
  logic [SIZE-1:0]     acc_q, acc_d;
  logic [SIZE-1:0]     q_q, q_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2*SIZE-1:0]   product_q, product_d;
  logic                done_q, done_d;

  logic [SIZE-1:0]     addend;
  logic [SIZE-1:0]     sum;
  logic                carry;
  logic [SIZE-1:0]     acc_sh, q_sh;

  assign addend = q_q[0] ? m_q : '0;

  seq_shift_add_multiplier_addsub #(
    .size (SIZE)
  ) u_addsub (
    .a    (acc_q),
    .b    (addend),
    .mode (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // {C,Sum,Q} >> 1: the carry lands in the top of Acc, so nothing is ever lost.
  assign acc_sh = {carry, sum[SIZE-1:1]};
  assign q_sh   = {sum[0], q_q[SIZE-1:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          count_d = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d   = acc_sh;
        q_d     = q_sh;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          // Register the final value on the way into DONE so done and product
          // appear together in the cycle after the last iteration.
          product_d = {acc_sh, q_sh};
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed cases on a SIZE=5
// instance, then randomized operands on SIZE=5 and SIZE=8 instances against A*B.
module tb_seq_shift_add_multiplier;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel   = 1'b0;  // 0: drive/observe the SIZE=5 instance, 1: SIZE=8
  logic [7:0]  a_drv = '0;
  logic [7:0]  b_drv = '0;

  logic        start5, start8;
  logic [9:0]  product5;
  logic [15:0] product8;
  logic        busy5, done5, busy8, done8;

  logic [15:0] prod_obs;
  logic        busy_obs, done_obs;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign start5   = start & ~sel;
  assign start8   = start & sel;
  assign prod_obs = sel ? product8 : {6'b0, product5};
  assign busy_obs = sel ? busy8 : busy5;
  assign done_obs = sel ? done8 : done5;

  seq_shift_add_multiplier #(.SIZE(5)) dut5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start5),
    .A       (a_drv[4:0]),
    .B       (b_drv[4:0]),
    .product (product5),
    .busy    (busy5),
    .done    (done5)
  );

  seq_shift_add_multiplier #(.SIZE(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .A       (a_drv),
    .B       (b_drv),
    .product (product8),
    .busy    (busy8),
    .done    (done8)
  );

  // Count every done pulse from either instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (done5) done_cnt++;
    if (done8) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input int a, input int b);
    a_drv = 8'(a);
    b_drv = 8'(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_drv = 8'($urandom);
    b_drv = 8'($urandom);
  endtask

  // Waits for done; product must hold its previous value until then.
  task automatic wait_done(input logic [31:0] prev, output int lat, output int busy_cyc);
    lat      = 1;
    busy_cyc = 0;
    while (!done_obs && lat < 40) begin
      if (busy_obs) busy_cyc++;
      check_eq("hold_before_done", 32'(prod_obs), prev);
      @(negedge clk);
      lat++;
    end
    if (busy_obs) busy_cyc++;
    check_eq("done_seen", 32'(done_obs), 32'd1);
  endtask

  // Full operation; ends one cycle after done with the DUT back in IDLE.
  task automatic do_op(input int sz, input int a, input int b, input logic [31:0] prev,
                       input string tag, output int lat);
    int          busy_cyc;
    logic [31:0] exp;
    exp = 32'(a * b);
    issue(a, b);
    wait_done(prev, lat, busy_cyc);
    check_eq({tag, "_latency"}, 32'(lat), 32'(sz + 1));
    check_eq({tag, "_product"}, 32'(prod_obs), exp);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(sz + 1));
    @(negedge clk);
    check_eq({tag, "_done_one_cycle"}, 32'(done_obs), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy_obs), 32'd0);
    check_eq({tag, "_held"}, 32'(prod_obs), exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2, busy_cyc, cnt_before, gap;
    logic [31:0] model5, model8;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_product", 32'(prod_obs), 32'd0);
    check_eq("reset_busy", 32'(busy_obs), 32'd0);
    check_eq("reset_done", 32'(done_obs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and extreme operands
    do_op(5, 13, 11, 32'd0, "basic", lat);
    do_op(5, 31, 31, 32'd143, "max", lat);
    do_op(5, 0, 27, 32'd961, "zero_a", lat);
    do_op(5, 27, 0, 32'd0, "zero_b", lat);

    // Start during CALC is ignored
    #1 cnt_before = done_cnt;
    @(negedge clk);
    issue(5, 6);                // now in first CALC cycle
    @(negedge clk);
    a_drv = 8'd9;
    b_drv = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(32'd0, lat, busy_cyc);
    check_eq("ign_latency", 32'(lat), 32'd4);
    check_eq("ign_product", 32'(prod_obs), 32'd30);
    repeat (10) @(negedge clk);
    check_eq("ign_product_after", 32'(prod_obs), 32'd30);
    #1 check_eq("ign_single_done", 32'(done_cnt), 32'(cnt_before + 1));

    // Reset mid-operation
    @(negedge clk);
    issue(7, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy_obs), 32'd0);
    check_eq("midrst_done", 32'(done_obs), 32'd0);
    check_eq("midrst_product", 32'(prod_obs), 32'd0);
    rst_n = 1'b1;
    #1 cnt_before = done_cnt;
    repeat (15) @(negedge clk);
    check_eq("midrst_product_later", 32'(prod_obs), 32'd0);
    #1 check_eq("midrst_no_done", 32'(done_cnt), 32'(cnt_before));

    // Back-to-back: second start in the first IDLE cycle after done
    @(negedge clk);
    do_op(5, 2, 3, 32'd0, "b2b_first", lat);
    do_op(5, 4, 5, 32'd6, "b2b_second", lat2);
    gap = lat2 + 1;             // trailing idle negedge + issue + (lat2 - 1)
    check_eq("b2b_done_spacing", 32'(gap), 32'd7);

    // Random regression on both widths
    model5 = 32'd20;
    model8 = 32'd0;
    for (int sz_i = 0; sz_i < 2; sz_i++) begin
      sel = (sz_i == 1);
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        int          sz, a, b;
        logic [31:0] prev;
        sz   = sel ? 8 : 5;
        a    = int'($urandom_range(0, (1 << sz) - 1));
        b    = int'($urandom_range(0, (1 << sz) - 1));
        prev = sel ? model8 : model5;
        do_op(sz, a, b, prev, sel ? "rand8" : "rand5", lat);
        if (sel) model8 = 32'(a * b);
        else     model5 = 32'(a * b);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          check_eq("rand_idle_hold", 32'(prod_obs), sel ? model8 : model5);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Sequential unsigned shift-add multiplier: the multiply-side counterpart of the team's restoring divider.
- Accepts two SIZE-bit operands on a start pulse and iterates one partial product per clock.
- Presents a 2*SIZE-bit product with a one-cycle done pulse.
- Sits beside the divider in the arithmetic datapath and reuses the same ripple adder/subtractor cell.

Parameters:
- SIZE, 5, operand width in bits (>=2); product is 2*SIZE bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset.
- start  input  1  request; sampled only in IDLE.
- A  input  SIZE  multiplicand, unsigned; captured when start is accepted.
- B  input  SIZE  multiplier, unsigned; captured when start is accepted.
- product  output  2*SIZE  A*B result; registered, held until next completion.
- busy  output  1  high while an operation is in progress (CALC or DONE).
- done  output  1  single-cycle pulse; product valid from this cycle onward.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: on rst_n=0 at a clock edge, state=IDLE, product=0, done=0, busy=0, internal Acc/Q/M/count=0.
- Reset mid-operation: aborts the operation; no done pulse is issued and the partial result is discarded.
- Internal registers:
  - M[SIZE-1:0]: multiplicand.
  - Acc[SIZE-1:0]: upper half.
  - Q[SIZE-1:0]: multiplier, becomes lower half.
  - count: $clog2(SIZE) bits minimum.
- IDLE:
  - busy=0, done=0.
  - If start=1: M<=A, Q<=B, Acc<=0, count<=0, next=CALC.
  - start=0: stay.
- CALC (exactly SIZE cycles), each cycle:
  - Sum = Acc + (Q[0] ? M : 0) via the adder in add mode, producing carry C.
  - {Acc,Q} <= {C,Sum,Q} >> 1 (logical right shift of the SIZE*2+1-bit concatenation).
  - count<=count+1.
  - When count==SIZE-1, next=DONE.
- DONE (1 cycle):
  - product<={Acc,Q}, done=1, busy=1, next=IDLE.
  - done is registered so it is high exactly one cycle.
- Latency:
  - start sampled at edge 0 gives CALC at edges 1..SIZE and DONE state during cycle SIZE+1.
  - done is high and product valid in the cycle following the last CALC, i.e. SIZE+1 cycles after start accepted.
  - Throughput is one result per SIZE+2 cycles.
- start while busy (CALC or DONE): ignored, no effect on the running operation. A and B may change freely after acceptance.
- Back-to-back: start high in the cycle after done (state back in IDLE) is accepted normally.
- Width rules: no overflow possible; the carry C is always absorbed by the right shift. Maximum product is (2^SIZE-1)^2.
- Operand edge cases: A=0 or B=0 gives product 0 after full latency. No early termination.
- product is not cleared on start; it holds the previous result until the next DONE.

Decomposition:
- Shared arithmetic package: state encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2. The default SIZE constant is shared with the divider.
- Sub-module: reuse the existing AddSub ripple adder (parameter size=SIZE, mode tied 0, B input = Q[0]-gated M, cout = C).
- FSM, counter and shift registers live in seq_shift_add_multiplier itself.

Test Plan:
- Basic multiply: SIZE=5, reset, then start=1 one cycle with A=13, B=11 -> done high exactly 6 cycles after start edge, product=10'd143, busy high for 6 cycles.
- Maximum operands: A=31, B=31 -> product=10'd961. Then A=0, B=27 -> product=0 after same latency.
- Ignored start: start with A=5, B=6, then assert start with A=9, B=9 during CALC -> product=30, exactly one done pulse.
- Mid-operation reset: start A=7, B=3, drop rst_n at cycle 3 -> busy=0, done=0, product=0; no done pulse ever follows.
- Back-to-back: start A=2, B=3; reassert start in the cycle after done with A=4, B=5 -> product 6 then 20, done pulses 7 cycles apart.
- Random regression: 1000 random A/B pairs at SIZE=5 and SIZE=8 compared against a reference A*B model; product must hold between done pulses.
